// File: rtl/feistel_round_ctrl_if.sv
// Block handshake bundle for feistel_round_ctrl: input-block and output-block channels.
// The master side feeds blocks in and consumes results; the slave side is the round controller.
interface feistel_round_ctrl_if #(
  parameter int HALF_W = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [2*HALF_W-1:0]   in_block;
  logic                  decrypt;
  logic                  out_valid;
  logic                  out_ready;
  logic [2*HALF_W-1:0]   out_block;

  modport master (
    output in_valid, in_block, decrypt, out_ready,
    input  in_ready, out_valid, out_block
  );

  modport slave (
    input  in_valid, in_block, decrypt, out_ready,
    output in_ready, out_valid, out_block
  );
endinterface

// File: rtl/feistel_round_ctrl.sv
// Iterative Feistel round controller: holds L/R, sequences rounds/key index, emits swapped block.
// Define FEISTEL_PIPE_F_EN to register f_out (f_q) in an extra FWAIT state, giving 2-cycle rounds.
module feistel_round_ctrl #(
  parameter int ROUNDS = 16,
  parameter int HALF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  feistel_round_ctrl_if.slave bus,
  output logic [HALF_W-1:0] f_r,
  output logic [3:0]        key_idx,
  input  logic [HALF_W-1:0] f_out,
  output logic              busy
);

  localparam logic [3:0] LAST = 4'(ROUNDS - 1);

`ifdef FEISTEL_PIPE_F_EN
  typedef enum logic [1:0] {IDLE, FWAIT, RUN, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
`endif

  state_t                state;
  logic [HALF_W-1:0]     l_q;
  logic [HALF_W-1:0]     r_q;
  logic [3:0]            round_q;
  logic                  dec_q;
  logic [2*HALF_W-1:0]   out_block_q;
  logic                  in_ready_q;
  logic                  out_valid_q;
  logic                  busy_q;
  logic [HALF_W-1:0]     f_use;
  logic [HALF_W-1:0]     r_next;

`ifdef FEISTEL_PIPE_F_EN
  logic [HALF_W-1:0]     f_q;
  assign f_use = f_q;
`else
  assign f_use = f_out;
`endif

  assign r_next  = l_q ^ f_use;
  assign f_r     = r_q;
  assign key_idx = dec_q ? (LAST - round_q) : round_q;

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_block = out_block_q;
  assign busy          = busy_q;

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      l_q         <= '0;
      r_q         <= '0;
      round_q     <= '0;
      dec_q       <= 1'b0;
      out_block_q <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef FEISTEL_PIPE_F_EN
      f_q         <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            l_q        <= bus.in_block[2*HALF_W-1:HALF_W];
            r_q        <= bus.in_block[HALF_W-1:0];
            round_q    <= '0;
            dec_q      <= bus.decrypt;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
`ifdef FEISTEL_PIPE_F_EN
            state      <= FWAIT;
`else
            state      <= RUN;
`endif
          end
        end

`ifdef FEISTEL_PIPE_F_EN
        FWAIT: begin
          f_q   <= f_out;
          state <= RUN;
        end
`endif

        RUN: begin
          l_q <= r_q;
          r_q <= r_next;
          // Counter holds at the last round rather than wrapping; accept clears it.
          if (round_q == LAST) begin
            out_block_q <= {r_next, r_q};
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            round_q <= round_q + 4'd1;
`ifdef FEISTEL_PIPE_F_EN
            state   <= FWAIT;
`else
            state   <= RUN;
`endif
          end
        end

        DONE: begin
          if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end

        default: begin
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_feistel_round_ctrl.sv
// Scoreboard bench for feistel_round_ctrl: a 16-round instance with a bench-driven f-path and a
// 1-round instance with identity f; latency scales when FEISTEL_PIPE_F_EN is defined.
module tb_feistel_round_ctrl;

`ifdef FEISTEL_PIPE_F_EN
  localparam int HOLD = 2;
`else
  localparam int HOLD = 1;
`endif
  localparam int LAT16 = HOLD * 16 + 1;
  localparam int LAT1  = HOLD * 1 + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  feistel_round_ctrl_if #(.HALF_W(32)) b16 ();
  feistel_round_ctrl_if #(.HALF_W(32)) b1 ();

  logic [31:0] f_r16, f_out16, f_r1, f_out1;
  logic [3:0]  k16, k1;
  logic        busy16, busy1;
  bit          fmode = 1'b0;

  feistel_round_ctrl #(.ROUNDS(16), .HALF_W(32)) dut16 (
    .clk(clk), .rst(rst), .bus(b16), .f_r(f_r16), .key_idx(k16), .f_out(f_out16), .busy(busy16)
  );

  feistel_round_ctrl #(.ROUNDS(1), .HALF_W(32)) dut1 (
    .clk(clk), .rst(rst), .bus(b1), .f_r(f_r1), .key_idx(k1), .f_out(f_out1), .busy(busy1)
  );

  int checks = 0;
  int errors = 0;
  logic [63:0] sb16[$];
  logic [63:0] sb1[$];

  function automatic logic [31:0] f_key(input logic [31:0] r, input logic [3:0] k);
    return ({r[26:0], r[31:27]} + {8{k}}) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [63:0] feistel_ref(input logic [63:0] blk, input logic dec);
    logic [31:0] l, r, t;
    logic [3:0]  k;
    l = blk[63:32];
    r = blk[31:0];
    for (int i = 0; i < 16; i++) begin
      k = dec ? 4'(15 - i) : 4'(i);
      t = l ^ f_key(r, k);
      l = r;
      r = t;
    end
    return {r, l};
  endfunction

  assign f_out16 = fmode ? f_key(f_r16, k16) : 32'h0;
  assign f_out1  = f_r1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Output monitors: pop and compare on every completed output handshake.
  always @(negedge clk) begin
    if (!rst && b16.out_valid && b16.out_ready) begin
      if (sb16.size() == 0) begin
        checks++; errors++;
        $display("FAIL out16_unexpected: got %h expected no output", b16.out_block);
      end else begin
        check("out_block16", b16.out_block, sb16.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && b1.out_valid && b1.out_ready) begin
      if (sb1.size() == 0) begin
        checks++; errors++;
        $display("FAIL out1_unexpected: got %h expected no output", b1.out_block);
      end else begin
        check("out_block1", b1.out_block, sb1.pop_front());
      end
    end
  end

  task automatic check_reset_outputs();
    check("rst_in_ready16", b16.in_ready, 1);
    check("rst_out_valid16", b16.out_valid, 0);
    check("rst_busy16", busy16, 0);
    check("rst_key_idx16", k16, 0);
    check("rst_f_r16", f_r16, 0);
    check("rst_out_block16", b16.out_block, 0);
  endtask

  task automatic run16(input logic [63:0] blk, input logic dec, input logic [63:0] exp,
                       input bit intrude, input int abort_round);
    int cyc;
    int idx;
    check("in_ready_idle16", b16.in_ready, 1);
    sb16.push_back(exp);
    b16.in_block = blk;
    b16.decrypt  = dec;
    b16.in_valid = 1'b1;
    @(posedge clk); #1;
    b16.in_valid = 1'b0;
    b16.in_block = ~blk;
    b16.decrypt  = ~dec;
    check("f_r_after_accept", f_r16, blk[31:0]);
    check("busy_after_accept", busy16, 1);
    check("in_ready_busy", b16.in_ready, 0);
    cyc = 1;
    while (!b16.out_valid && cyc <= LAT16 + 4) begin
      idx = (cyc - 1) / HOLD;
      if (idx < 16) check("key_idx16", k16, dec ? 15 - idx : idx);
      if (idx == abort_round && (cyc - 1) % HOLD == 0) begin
        #2 rst = 1'b1;
        #1 check_reset_outputs();
        sb16.delete();
        #2 rst = 1'b0;
        @(posedge clk); #1;
        return;
      end
      b16.in_valid = intrude && (cyc == 4);
      b16.in_block = 64'hDEAD_BEEF_CAFE_F00D;
      @(posedge clk); #1;
      cyc++;
    end
    b16.in_valid = 1'b0;
    check("latency16", cyc, LAT16);
  endtask

  task automatic wait_idle16();
    int n = 0;
    while (!b16.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("return_idle16", b16.in_ready, 1);
    check("out_valid_dropped16", b16.out_valid, 0);
  endtask

  task automatic run1(input logic [63:0] blk, input logic dec, input logic [63:0] exp);
    int cyc;
    int n = 0;
    sb1.push_back(exp);
    b1.in_block = blk;
    b1.decrypt  = dec;
    b1.in_valid = 1'b1;
    @(posedge clk); #1;
    b1.in_valid = 1'b0;
    check("key_idx1", k1, 0);
    cyc = 1;
    while (!b1.out_valid && cyc <= LAT1 + 4) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("latency1", cyc, LAT1);
    while (!b1.in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("return_idle1", b1.in_ready, 1);
  endtask

  initial begin
    logic [63:0] p;
    logic [63:0] c;
    b16.in_valid = 1'b0; b16.in_block = '0; b16.decrypt = 1'b0; b16.out_ready = 1'b1;
    b1.in_valid  = 1'b0; b1.in_block  = '0; b1.decrypt  = 1'b0; b1.out_ready  = 1'b1;

    #1 rst = 1'b1;
    #2 check_reset_outputs();
    check("rst_in_ready1", b1.in_ready, 1);
    check("rst_busy1", busy1, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Null f: even round count returns the halves swapped.
    fmode = 1'b0;
    run16(64'h01234567_89ABCDEF, 1'b0, 64'h89ABCDEF_01234567, 1'b0, -1);
    wait_idle16();

    // Keyed f: encrypt against the reference, then decrypt must restore the plaintext.
    fmode = 1'b1;
    p = 64'h0F1E2D3C_4B5A6978;
    c = feistel_ref(p, 1'b0);
    run16(p, 1'b0, c, 1'b0, -1);
    wait_idle16();
    run16(c, 1'b1, p, 1'b0, -1);
    wait_idle16();

    // Backpressure with an intruding block during RUN.
    fmode = 1'b0;
    b16.out_ready = 1'b0;
    run16(64'hFEDCBA98_76543210, 1'b0, 64'h76543210_FEDCBA98, 1'b1, -1);
    repeat (10) begin
      check("bp_out_block", b16.out_block, 64'h76543210_FEDCBA98);
      check("bp_out_valid", b16.out_valid, 1);
      check("bp_in_ready", b16.in_ready, 0);
      @(posedge clk); #1;
    end
    b16.out_ready = 1'b1;
    wait_idle16();
    repeat (20) begin
      check("ignored_block_idle", busy16, 0);
      @(posedge clk); #1;
    end
    check("sb16_drained", sb16.size(), 0);

    // Reset at round 7, then a fresh block completes normally.
    run16(64'h01234567_89ABCDEF, 1'b0, 64'h89ABCDEF_01234567, 1'b0, 7);
    check("post_rst_in_ready", b16.in_ready, 1);
    run16(64'h01234567_89ABCDEF, 1'b0, 64'h89ABCDEF_01234567, 1'b0, -1);
    wait_idle16();

    // Single-round instance with identity f.
    run1(64'h0000000F_000000F0, 1'b0, 64'h000000FF_000000F0);
    run1(64'h12345678_00000001, 1'b1, 64'h12345679_00000001);

    repeat (3) @(posedge clk);
    check("sb16_empty", sb16.size(), 0);
    check("sb1_empty", sb1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
